uart_tx: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ==================================================================
// uart_pkg : shared UART states, line levels and parity helper
// Rev 1.0
// ==================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ==================================================================
// uart_bit_timer : bit-period counter producing the bit-end strobe
// Rev 1.0
// ==================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk_t,
  input  logic srst,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_t or posedge srst) begin
    if (srst) begin
      r_cnt <= '0;
    end else if (restart || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ==================================================================
// uart_tx : UART transmitter with one-entry holding register
// Rev 1.0
// ==================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_t,
  input  logic                 srst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_cnt;
  logic                 r_tx;
  logic                 r_tx_done;

  logic w_bit_end;
  logic w_restart;
  logic w_accept;
  logic w_load;
  logic w_frame_end;
  logic w_last_stop;
  logic w_line;

  assign w_accept    = data_valid && !r_hold_full;
  assign w_last_stop = (STOP_BITS < 2) || r_stop_cnt;
  assign w_restart   = (w_state_next != r_state);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_t  (clk_t),
    .srst   (srst),
    .restart(w_restart),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk_t or posedge srst) begin
    if (srst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_frame_end  = 1'b0;
    w_line       = LINE_IDLE;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load       = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        w_line = START_LVL;
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        w_line = r_shift[0];
        if (w_bit_end && (r_bit_idx == IDX_W'(DATA_BITS - 1))) begin
          w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_line = r_parity;
        if (w_bit_end) w_state_next = STOP;
      end
      STOP: begin
        w_line = STOP_LVL;
        // A buffered byte chains straight into the next start bit.
        if (w_bit_end && w_last_stop) begin
          w_frame_end = 1'b1;
          if (r_hold_full) begin
            w_load       = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_t or posedge srst) begin
    if (srst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_tx        <= LINE_IDLE;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx      <= w_line;
      r_tx_done <= w_frame_end;

      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_data <= data_in;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shift  <= r_hold_data;
        r_parity <= even_parity(r_hold_data);
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end

      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (r_state != STOP) begin
        r_stop_cnt <= 1'b0;
      end else if (w_bit_end) begin
        r_stop_cnt <= ~r_stop_cnt;
      end
    end
  end

  assign ready   = !r_hold_full;
  assign tx      = r_tx;
  assign busy    = (r_state != IDLE);
  assign tx_done = r_tx_done;

endmodule
`default_nettype wire
